// File: rtl/follow_ctrl.sv
// Frame-rate motion controller: SEARCH/TRACK/HOLD sequencing from centroid
// frames, with lost-target filtering, proximity hysteresis and a watchdog.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   enable_i          behaviour enable; low forces IDLE
//   new_centroid_i    one-cycle pulse qualifying centroid_i / proximity_i
//   centroid_i        position code (bit 0 leftmost), 0 = no target
//   proximity_i       target proximity (0 far .. max close)
//   motor_l_o/_r_o    motor commands: 00 stop, 01 forward, 10 backward
//   state_o           0 IDLE, 1 SEARCH, 2 TRACK, 3 HOLD, 4 STALL
//   cmd_valid_o       one-cycle pulse when the outputs are re-evaluated
//   lost_o            high while the lost-frame counter is non-zero
module follow_ctrl #(
    parameter int c_nb_centroid = 8,
    parameter int c_nb_prox     = 3,
    parameter int c_lost_frames = 8,
    parameter int c_prox_stop   = 6,
    parameter int c_prox_go     = 4,
    parameter int c_wdog_clks   = 5_000_000,
    parameter int c_nb_wdog     = $clog2(c_wdog_clks + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable_i,
    input  logic                     new_centroid_i,
    input  logic [c_nb_centroid-1:0] centroid_i,
    input  logic [c_nb_prox-1:0]     proximity_i,
    output logic [1:0]               motor_l_o,
    output logic [1:0]               motor_r_o,
    output logic [2:0]               state_o,
    output logic                     cmd_valid_o,
    output logic                     lost_o
);

    localparam int c_half    = c_nb_centroid / 2;
    localparam int c_nb_lost = $clog2(c_lost_frames + 1);

    localparam logic [1:0] MOT_STOP = 2'b00;
    localparam logic [1:0] MOT_FWD  = 2'b01;
    localparam logic [1:0] MOT_BWD  = 2'b10;

    // The two innermost bits together mean "dead ahead".
    localparam logic [c_nb_centroid-1:0] c_centered =
        c_nb_centroid'(3) << (c_half - 1);

    localparam logic [c_nb_prox:0] c_stop_thr =
        (c_nb_prox + 1)'(c_prox_stop);
    localparam logic [c_nb_prox:0] c_go_thr =
        (c_nb_prox + 1)'(c_prox_go);

    localparam logic [c_nb_lost-1:0] c_lost_max =
        c_nb_lost'(c_lost_frames);
    localparam logic [c_nb_wdog-1:0] c_wdog_max =
        c_nb_wdog'(c_wdog_clks);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_TRACK  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_STALL  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             mot_l_q, mot_l_d;
    logic [1:0]             mot_r_q, mot_r_d;
    logic                   side_q, side_d;
    logic [c_nb_lost-1:0]   lost_cnt_q, lost_cnt_d;
    logic [c_nb_wdog-1:0]   wdog_q, wdog_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic                   lost_q, lost_d;

    logic                   tgt_valid;
    logic                   prox_stop;
    logic                   prox_release;
    logic                   hold_req;
    logic [c_nb_lost-1:0]   lost_inc;
    logic                   lost_expire;
    logic [c_nb_wdog-1:0]   wdog_inc;
    logic                   wdog_expire;

    logic [1:0]             steer_l, steer_r;
    logic                   steer_side;
    logic [1:0]             spin_l, spin_r;

    assign tgt_valid    = |centroid_i;
    assign prox_stop    = {1'b0, proximity_i} >= c_stop_thr;
    assign prox_release = {1'b0, proximity_i} < c_go_thr;

    // Hysteresis: TRACK stops at the upper threshold, HOLD only releases
    // below the lower one.
    assign hold_req = (state_q == ST_TRACK) ? prox_stop : !prox_release;

    assign lost_inc    = lost_cnt_q + c_nb_lost'(1);
    assign lost_expire = lost_inc == c_lost_max;
    assign wdog_inc    = wdog_q + c_nb_wdog'(1);
    assign wdog_expire = wdog_inc == c_wdog_max;

    // Steering from the position code. The left half has priority; within
    // it the innermost bit gives a gentle pivot, the outer bits a spin.
    always_comb begin
        steer_l    = MOT_FWD;
        steer_r    = MOT_FWD;
        steer_side = side_q;
        if (centroid_i == c_centered) begin
            steer_l = MOT_FWD;
            steer_r = MOT_FWD;
        end else if (|centroid_i[c_half-1:0]) begin
            steer_side = 1'b0;
            steer_r    = MOT_FWD;
            if (centroid_i[c_half-2:0] == '0) begin
                steer_l = MOT_STOP;
            end else begin
                steer_l = MOT_BWD;
            end
        end else begin
            steer_side = 1'b1;
            steer_l    = MOT_FWD;
            if (centroid_i[c_nb_centroid-1:c_half+1] == '0) begin
                steer_r = MOT_STOP;
            end else begin
                steer_r = MOT_BWD;
            end
        end
    end

    // Search spins toward the side the target was last seen on.
    always_comb begin
        spin_l = side_q ? MOT_FWD : MOT_BWD;
        spin_r = side_q ? MOT_BWD : MOT_FWD;
    end

    always_comb begin
        state_d     = state_q;
        mot_l_d     = mot_l_q;
        mot_r_d     = mot_r_q;
        side_d      = side_q;
        lost_cnt_d  = lost_cnt_q;
        wdog_d      = wdog_q;
        cmd_valid_d = 1'b0;

        if (!enable_i) begin
            state_d     = ST_IDLE;
            mot_l_d     = MOT_STOP;
            mot_r_d     = MOT_STOP;
            lost_cnt_d  = '0;
            wdog_d      = '0;
            cmd_valid_d = state_q != ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d     = ST_SEARCH;
                    mot_l_d     = spin_l;
                    mot_r_d     = spin_r;
                    lost_cnt_d  = '0;
                    wdog_d      = '0;
                    cmd_valid_d = 1'b1;
                end

                // STALL re-acquires with the same rules as SEARCH, but
                // its watchdog stays frozen while waiting.
                ST_SEARCH, ST_STALL: begin
                    if (new_centroid_i) begin
                        cmd_valid_d = 1'b1;
                        wdog_d      = '0;
                        lost_cnt_d  = '0;
                        if (!tgt_valid) begin
                            state_d = ST_SEARCH;
                            mot_l_d = spin_l;
                            mot_r_d = spin_r;
                        end else if (prox_stop) begin
                            state_d = ST_HOLD;
                            mot_l_d = MOT_STOP;
                            mot_r_d = MOT_STOP;
                        end else begin
                            state_d = ST_TRACK;
                            mot_l_d = steer_l;
                            mot_r_d = steer_r;
                            side_d  = steer_side;
                        end
                    end else if (state_q == ST_SEARCH) begin
                        wdog_d = wdog_inc;
                        if (wdog_expire) begin
                            state_d     = ST_STALL;
                            mot_l_d     = MOT_STOP;
                            mot_r_d     = MOT_STOP;
                            lost_cnt_d  = '0;
                            cmd_valid_d = 1'b1;
                        end
                    end
                end

                ST_TRACK, ST_HOLD: begin
                    if (new_centroid_i) begin
                        cmd_valid_d = 1'b1;
                        wdog_d      = '0;
                        if (tgt_valid) begin
                            lost_cnt_d = '0;
                            if (hold_req) begin
                                state_d = ST_HOLD;
                                mot_l_d = MOT_STOP;
                                mot_r_d = MOT_STOP;
                            end else begin
                                state_d = ST_TRACK;
                                mot_l_d = steer_l;
                                mot_r_d = steer_r;
                                side_d  = steer_side;
                            end
                        end else if (lost_expire) begin
                            state_d    = ST_SEARCH;
                            mot_l_d    = spin_l;
                            mot_r_d    = spin_r;
                            lost_cnt_d = '0;
                        end else begin
                            // Coast on the previous command while the
                            // target is briefly missing.
                            lost_cnt_d = lost_inc;
                        end
                    end else begin
                        wdog_d = wdog_inc;
                        if (wdog_expire) begin
                            state_d     = ST_STALL;
                            mot_l_d     = MOT_STOP;
                            mot_r_d     = MOT_STOP;
                            lost_cnt_d  = '0;
                            cmd_valid_d = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d     = ST_IDLE;
                    mot_l_d     = MOT_STOP;
                    mot_r_d     = MOT_STOP;
                    lost_cnt_d  = '0;
                    wdog_d      = '0;
                    cmd_valid_d = 1'b1;
                end
            endcase
        end
    end

    assign lost_d = lost_cnt_d != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mot_l_q     <= MOT_STOP;
            mot_r_q     <= MOT_STOP;
            side_q      <= 1'b0;
            lost_cnt_q  <= '0;
            wdog_q      <= '0;
            cmd_valid_q <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mot_l_q     <= mot_l_d;
            mot_r_q     <= mot_r_d;
            side_q      <= side_d;
            lost_cnt_q  <= lost_cnt_d;
            wdog_q      <= wdog_d;
            cmd_valid_q <= cmd_valid_d;
            lost_q      <= lost_d;
        end
    end

    assign motor_l_o   = mot_l_q;
    assign motor_r_o   = mot_r_q;
    assign state_o     = state_q;
    assign cmd_valid_o = cmd_valid_q;
    assign lost_o      = lost_q;

endmodule

// File: tb/tb_follow_ctrl.sv
// Testbench for follow_ctrl: directed vector table, watchdog sequences
// and randomized frames against a behavioural model.
module tb_follow_ctrl;

    localparam int WD   = 20;
    localparam int LOST = 8;
    localparam int STOP = 6;
    localparam int GO   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable_i;
    logic       new_centroid_i;
    logic [7:0] centroid_i;
    logic [2:0] proximity_i;
    logic [1:0] motor_l_o;
    logic [1:0] motor_r_o;
    logic [2:0] state_o;
    logic       cmd_valid_o;
    logic       lost_o;

    follow_ctrl #(.c_wdog_clks(WD)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable_i),
        .new_centroid_i(new_centroid_i),
        .centroid_i    (centroid_i),
        .proximity_i   (proximity_i),
        .motor_l_o     (motor_l_o),
        .motor_r_o     (motor_r_o),
        .state_o       (state_o),
        .cmd_valid_o   (cmd_valid_o),
        .lost_o        (lost_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       r;
        logic       e;
        logic       p;
        logic [7:0] c;
        logic [2:0] x;
        int         s;
        int         l;
        int         rr;
        int         cv;
        int         lo;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic r, e, p, input logic [7:0] c,
                                input logic [2:0] x, input int s, l, rr,
                                cv, lo);
        vec_t v;
        v.r = r; v.e = e; v.p = p; v.c = c; v.x = x;
        v.s = s; v.l = l; v.rr = rr; v.cv = cv; v.lo = lo;
        return v;
    endfunction

    task automatic apply(input logic r, e, pl, input logic [7:0] c,
                         input logic [2:0] x);
        rst            = r;
        enable_i       = e;
        new_centroid_i = pl;
        centroid_i     = c;
        proximity_i    = x;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int s, l, rr, cv, lo);
        total++;
        if (state_o !== 3'(s) || motor_l_o !== 2'(l) ||
            motor_r_o !== 2'(rr) || cmd_valid_o !== 1'(cv) ||
            lost_o !== 1'(lo)) begin
            bad++;
            $display("FAIL %s: got state=%0d L=%b R=%b cv=%b lost=%b, want state=%0d L=%0d R=%0d cv=%0d lost=%0d",
                     nm, state_o, motor_l_o, motor_r_o, cmd_valid_o,
                     lost_o, s, l, rr, cv, lo);
        end
    endtask

    // Behavioural model; motor codes 0 stop, 1 fwd, 2 back.
    int ms, ml, mr, mcv, mlost, mside, mwd;

    task automatic m_spin();
        ml = mside ? 1 : 2;
        mr = mside ? 2 : 1;
    endtask

    task automatic m_stop();
        ml = 0;
        mr = 0;
    endtask

    task automatic m_steer(input logic [7:0] c);
        int lo;
        int hi;
        lo = -1;
        hi = -1;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        if (c == 8'h18) begin
            ml = 1; mr = 1;
        end else if (lo <= 3) begin
            mside = 0;
            ml = (lo == 3) ? 0 : 2;
            mr = 1;
        end else begin
            mside = 1;
            ml = 1;
            mr = (hi == 4) ? 0 : 2;
        end
    endtask

    task automatic model_step(input logic r, e, pl, input logic [7:0] c,
                              input logic [2:0] x);
        if (r) begin
            ms = 0; ml = 0; mr = 0; mcv = 0; mlost = 0; mside = 0; mwd = 0;
        end else if (!e) begin
            mcv = (ms != 0) ? 1 : 0;
            ms = 0; m_stop(); mlost = 0; mwd = 0;
        end else begin
            mcv = 0;
            if (ms == 0) begin
                ms = 1; m_spin(); mcv = 1;
            end else if (pl) begin
                mcv = 1;
                mwd = 0;
                if (ms == 1 || ms == 4) begin
                    mlost = 0;
                    if (c == 0) begin
                        ms = 1; m_spin();
                    end else if (x >= STOP) begin
                        ms = 3; m_stop();
                    end else begin
                        ms = 2; m_steer(c);
                    end
                end else if (c != 0) begin
                    mlost = 0;
                    if ((ms == 2 && x >= STOP) || (ms == 3 && x >= GO)) begin
                        ms = 3; m_stop();
                    end else begin
                        ms = 2; m_steer(c);
                    end
                end else begin
                    mlost++;
                    if (mlost == LOST) begin
                        ms = 1; mlost = 0; m_spin();
                    end
                end
            end else if (ms != 4) begin
                mwd++;
                if (mwd == WD) begin
                    ms = 4; m_stop(); mlost = 0; mcv = 1;
                end
            end
        end
    endtask

    initial begin
        int rate;
        int zpct;
        logic r, e, pl;
        logic [7:0] c;
        logic [2:0] x;

        rst = 1'b1; enable_i = 1'b0; new_centroid_i = 1'b0;
        centroid_i = '0; proximity_i = '0;

        vt.push_back(mk(1,0,0,8'h00,0, 0,0,0,0,0));
        vt.push_back(mk(0,1,0,8'h00,0, 1,2,1,1,0));
        vt.push_back(mk(0,1,0,8'h00,0, 1,2,1,0,0));
        vt.push_back(mk(0,1,1,8'h18,2, 2,1,1,1,0));
        vt.push_back(mk(0,1,1,8'h20,2, 2,1,2,1,0));
        for (int i = 0; i < 7; i++)
            vt.push_back(mk(0,1,1,8'h00,0, 2,1,2,1,1));
        vt.push_back(mk(0,1,1,8'h00,0, 1,1,2,1,0));
        vt.push_back(mk(0,1,0,8'h00,0, 1,1,2,0,0));
        vt.push_back(mk(0,1,1,8'h04,1, 2,2,1,1,0));
        vt.push_back(mk(0,1,1,8'h80,6, 3,0,0,1,0));
        vt.push_back(mk(0,1,1,8'h80,5, 3,0,0,1,0));
        vt.push_back(mk(0,1,1,8'h08,3, 2,0,1,1,0));
        vt.push_back(mk(0,1,1,8'h10,0, 2,1,0,1,0));
        vt.push_back(mk(0,1,1,8'h0C,0, 2,2,1,1,0));
        vt.push_back(mk(0,1,1,8'h30,0, 2,1,2,1,0));
        vt.push_back(mk(0,1,1,8'h18,7, 3,0,0,1,0));
        vt.push_back(mk(0,1,1,8'h00,0, 3,0,0,1,1));
        vt.push_back(mk(0,1,1,8'h01,4, 3,0,0,1,0));
        vt.push_back(mk(0,1,1,8'h01,3, 2,2,1,1,0));
        vt.push_back(mk(0,0,0,8'h00,0, 0,0,0,1,0));
        vt.push_back(mk(0,0,0,8'h00,0, 0,0,0,0,0));
        vt.push_back(mk(0,1,0,8'h00,0, 1,2,1,1,0));
        vt.push_back(mk(0,1,1,8'h40,6, 3,0,0,1,0));
        vt.push_back(mk(1,1,0,8'h00,0, 0,0,0,0,0));
        vt.push_back(mk(0,1,0,8'h00,0, 1,2,1,1,0));

        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i].r, vt[i].e, vt[i].p, vt[i].c, vt[i].x);
            check($sformatf("vec%0d", i), vt[i].s, vt[i].l, vt[i].rr,
                  vt[i].cv, vt[i].lo);
        end

        // Watchdog expiry out of SEARCH.
        for (int i = 1; i < WD; i++) begin
            apply(0,1,0,8'h00,0);
            check("wdog_pre", 1,2,1,0,0);
        end
        apply(0,1,0,8'h00,0);
        check("wdog_stall", 4,0,0,1,0);
        apply(0,1,0,8'h00,0);
        check("stall_wait", 4,0,0,0,0);
        apply(0,1,1,8'h00,0);
        check("stall_exit", 1,2,1,1,0);

        // Pulse on the would-be expiry cycle wins.
        for (int i = 1; i < WD; i++) begin
            apply(0,1,0,8'h00,0);
            check("race_pre", 1,2,1,0,0);
        end
        apply(0,1,1,8'h00,0);
        check("wdog_race", 1,2,1,1,0);
        apply(0,1,0,8'h00,0);
        check("race_after", 1,2,1,0,0);

        // Watchdog out of TRACK, then re-acquire from STALL.
        apply(0,1,1,8'h02,1);
        check("acq_track", 2,2,1,1,0);
        for (int i = 1; i < WD; i++) begin
            apply(0,1,0,8'h00,0);
            check("track_pre", 2,2,1,0,0);
        end
        apply(0,1,0,8'h00,0);
        check("wdog_track", 4,0,0,1,0);
        apply(0,1,1,8'h80,2);
        check("stall_acq", 2,1,2,1,0);

        // Randomized frames against the model.
        model_step(1,0,0,8'h00,0);
        apply(1,0,0,8'h00,0);
        check("rand_rst", ms, ml, mr, mcv, (mlost != 0) ? 1 : 0);
        rate = 2;
        zpct = 20;
        for (int n = 0; n < 4000; n++) begin
            if (n % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: rate = 1;
                    1: rate = 6;
                    default: rate = 30;
                endcase
                zpct = ($urandom_range(0, 1) == 0) ? 20 : 90;
            end
            r  = ($urandom_range(0, 499) == 0);
            e  = ($urandom_range(0, 59) != 0);
            pl = ($urandom_range(0, rate) == 0);
            if ($urandom_range(0, 99) < zpct) begin
                c = 8'h00;
            end else begin
                case ($urandom_range(0, 3))
                    0: c = 8'h01 << $urandom_range(0, 7);
                    1: c = 8'h03 << $urandom_range(0, 6);
                    2: c = 8'h18;
                    default: c = 8'($urandom);
                endcase
            end
            x = 3'($urandom_range(0, 7));
            model_step(r, e, pl, c, x);
            apply(r, e, pl, c, x);
            check("rand", ms, ml, mr, mcv, (mlost != 0) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
